keyboard_decoder: RTL
=====================

// Module: keyboard_decoder
// PURPOSE
//  Producer side of the keyboard_locker/keyboard_data interface consumed by Game_Player.
//  Receives raw PS/2 frames and decodes set-2 scancodes into 3-bit game commands.
//  Issues one single-cycle keyboard_locker strobe per accepted key press.
//  Sits between the board PS/2 pins and the game logic, in the system clock domain.
// PARAMETERS
//  TIMEOUT_CYCLES  200000  idle clocks mid-frame before the partial frame is discarded (2 ms @100 MHz)
//  TIMEOUT_WIDTH   18      counter width; must satisfy 2**TIMEOUT_WIDTH > TIMEOUT_CYCLES
// PORTS
//  clock           in   1  system clock
//  reset           in   1  asynchronous, active-high reset
//  ps2_clock       in   1  raw PS/2 clock pin, asynchronous
//  ps2_data        in   1  raw PS/2 data pin, asynchronous
//  keyboard_locker out  1  1-cycle strobe: keyboard_data carries a new command
//  keyboard_data   out  3  command code, held between strobes
// BEHAVIOUR
//  Reset: keyboard_locker=0, keyboard_data=3'd0, bit count=0, E0/F0 flags clear,
//   held key clear, timeout counter 0. Asserting reset mid-frame abandons the frame.
//  Sync: each PS/2 line passes through 2 FFs. Falling edge = sync'd clk 0 while prev 1.
//  Frame RX (counter 0..10, sampled on each falling edge): start(0), D0..D7 LSB first,
//   odd parity, stop(1). A byte is accepted only if start=0, parity odd, and stop=1.
//   Any bad frame is dropped silently; counter returns to 0.
//  Timeout: counter clears on every edge and counts while bit count!=0.
//   At TIMEOUT_CYCLES, bit count returns to 0 and the partial frame is dropped.
//  Byte FSM: IDLE --E0--> EXT; IDLE/EXT --F0--> BREAK (keeps ext flag).
//   From BREAK, the next byte is the released key. If it equals the held key, clear
//   held. No strobe. Return to IDLE.
//   From IDLE/EXT, other bytes are a make code {ext,code}.
//   If it equals the held key, it is a typematic repeat: ignore it.
//   Else, if it maps, set held={ext,code} and strobe. Return to IDLE.
//  Map (make): 0 UP = 1D(W) | E0 75; 1 DOWN = 1B(S) | E0 72; 2 LEFT = 1C(A) | E0 6B;
//   3 RIGHT = 23(D) | E0 74; 4 CONFIRM = 29(Space); 5 MODE = 1A(Z); 6 CANCEL = 76(Esc);
//   7 unused. Unmapped codes produce no strobe and do not change held.
//   E0 29/1A/76 are unmapped.
//  Strobe: a valid final byte is latched on the cycle of the stop-bit falling edge.
//   keyboard_data updates and keyboard_locker=1 on the next cycle, for exactly 1 cycle.
//   Fixed latency: 4 clocks from the pin falling edge to the strobe.
//   A 2nd strobe needs a full new frame, so at most 1 per frame.
//  keyboard_data never changes except together with a strobe.
// TESTING
//  T1 frame 0x1D (11-bit, ~80 us bit period) -> one strobe, data=0, exactly 4 clk after last edge.
//  T2 E0,74 then E0,F0,74 -> one strobe data=3; break produces nothing; data stays 3.
//  T3 1D,1D,1D,F0,1D,1D -> exactly two strobes, both data=0 (repeats suppressed).
//  T4 0x29 with even parity, then 0x29 with stop=0 -> no strobes; next clean 0x76 -> data=6.
//  T5 send 5 bits, idle TIMEOUT_CYCLES+1 clocks, then clean 0x1B -> one strobe data=1;
//     no strobe if idle < TIMEOUT_CYCLES and frame corrupts.
//  T6 reset pulse mid-frame after strobe data=5 -> locker=0, data=0; next clean 0x1C -> data=2.

Source files
------------

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 scancode receiver and decoder producing one-cycle game command strobes.
// Handles E0 extension, F0 break codes and suppresses typematic repeats of the held key.
module keyboard_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned TIMEOUT_WIDTH  = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       keyboard_locker,
    output logic [2:0] keyboard_data
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEY_W  = BYTE_W + 1;
    localparam int unsigned CMD_W  = 3;

    localparam logic [BYTE_W-1:0] CODE_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] CODE_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXT   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    // Two-flop synchronisers; idle-high reset values avoid a spurious edge after reset
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;
    logic       ps2_fall_c;
    logic       ps2_bit_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clock};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign ps2_fall_c = !clk_sync[1] && clk_prev;
    assign ps2_bit_c  = dat_sync[1];

    // Frame receiver with mid-frame idle timeout
    logic [CNT_W-1:0]         bit_cnt;
    logic [BYTE_W-1:0]        shift;
    logic                     start_ok;
    logic                     parity_ok;
    logic                     rx_valid;
    logic [TIMEOUT_WIDTH-1:0] timer;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift     <= '0;
            start_ok  <= 1'b0;
            parity_ok <= 1'b0;
            rx_valid  <= 1'b0;
            timer     <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (ps2_fall_c) begin
                timer <= '0;
                if (bit_cnt == CNT_W'(0)) begin
                    start_ok <= !ps2_bit_c;
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                end else if (bit_cnt <= CNT_W'(8)) begin
                    shift   <= {ps2_bit_c, shift[BYTE_W-1:1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end else if (bit_cnt == CNT_W'(9)) begin
                    parity_ok <= (^shift) ^ ps2_bit_c;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end else begin
                    bit_cnt  <= '0;
                    rx_valid <= (bit_cnt == CNT_W'(10)) && start_ok && parity_ok && ps2_bit_c;
                end
            end else if (bit_cnt != CNT_W'(0)) begin
                if (timer == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt <= '0;
                    timer   <= '0;
                end else begin
                    timer <= timer + TIMEOUT_WIDTH'(1);
                end
            end
        end
    end

    // {hit, command} for a make code
    function automatic logic [CMD_W:0] map_key(input logic ext, input logic [BYTE_W-1:0] code);
        logic [CMD_W:0] res;
        res = '0;
        if (ext) begin
            case (code)
                8'h75:   res = {1'b1, 3'd0};
                8'h72:   res = {1'b1, 3'd1};
                8'h6B:   res = {1'b1, 3'd2};
                8'h74:   res = {1'b1, 3'd3};
                default: res = '0;
            endcase
        end else begin
            case (code)
                8'h1D:   res = {1'b1, 3'd0};
                8'h1B:   res = {1'b1, 3'd1};
                8'h1C:   res = {1'b1, 3'd2};
                8'h23:   res = {1'b1, 3'd3};
                8'h29:   res = {1'b1, 3'd4};
                8'h1A:   res = {1'b1, 3'd5};
                8'h76:   res = {1'b1, 3'd6};
                default: res = '0;
            endcase
        end
        return res;
    endfunction

    state_t             state, state_d;
    logic               brk_ext, brk_ext_d;
    logic [KEY_W-1:0]   held_key, held_key_d;
    logic               held_valid, held_valid_d;
    logic               locker_d;
    logic [CMD_W-1:0]   data_d;
    logic [KEY_W-1:0]   make_key_c;
    logic [CMD_W:0]     map_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            brk_ext         <= 1'b0;
            held_key        <= '0;
            held_valid      <= 1'b0;
            keyboard_locker <= 1'b0;
            keyboard_data   <= '0;
        end else begin
            state           <= state_d;
            brk_ext         <= brk_ext_d;
            held_key        <= held_key_d;
            held_valid      <= held_valid_d;
            keyboard_locker <= locker_d;
            keyboard_data   <= data_d;
        end
    end

    assign make_key_c = {state == ST_EXT, shift};
    assign map_c      = map_key(state == ST_EXT, shift);

    always_comb begin
        state_d      = state;
        brk_ext_d    = brk_ext;
        held_key_d   = held_key;
        held_valid_d = held_valid;
        locker_d     = 1'b0;
        data_d       = keyboard_data;
        if (rx_valid) begin
            case (state)
                ST_BREAK: begin
                    if (held_valid && (held_key == {brk_ext, shift})) begin
                        held_valid_d = 1'b0;
                    end
                    brk_ext_d = 1'b0;
                    state_d   = ST_IDLE;
                end
                default: begin
                    if (shift == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (shift == CODE_BREAK) begin
                        brk_ext_d = (state == ST_EXT);
                        state_d   = ST_BREAK;
                    end else begin
                        state_d = ST_IDLE;
                        // Repeats of the held key are typematic and stay silent
                        if (!(held_valid && (held_key == make_key_c)) && map_c[CMD_W]) begin
                            held_key_d   = make_key_c;
                            held_valid_d = 1'b1;
                            locker_d     = 1'b1;
                            data_d       = map_c[CMD_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

endmodule
